// File: rtl/ext_trigger_bridge.sv
// ---------------------------------------------------------------------------
// ext_trigger_bridge
//   Bridges the debug trigger unit's external-trigger lines to the outside
//   world (CTI / other harts) over asynchronous 4-phase req/ack handshakes.
//
//   Inbound:  trig_in_req_i is synchronised. Each handshake produces at most
//             one single-cycle pulse on ext_trigger_o. No pulse is produced
//             when trig_in_mask_i was set as the handshake started.
//   Outbound: rising edges of core_ext_trigger_i are counted per channel.
//             One full req/ack handshake is sent for each counted event.
//
// Ports
//   clk                 core clock
//   reset_n             asynchronous active-low reset
//   trig_in_req_i       async inbound requests              [NUM_IN]
//   trig_in_ack_o       inbound acks, registered            [NUM_IN]
//   trig_in_mask_i      1 = complete handshake without pulse [NUM_IN]
//   ext_trigger_o       1-cycle pulse to the trigger unit   [NUM_IN]
//   core_ext_trigger_i  trigger unit outputs, sync level    [NUM_OUT]
//   trig_out_req_o      outbound requests, registered       [NUM_OUT]
//   trig_out_ack_i      async outbound acks                 [NUM_OUT]
//   trig_out_clear_i    zero pending counters and overflow flags
//   trig_out_pending_o  queued, not-yet-sent events         [NUM_OUT][PEND_W]
//   trig_out_overflow_o sticky: event lost at saturation    [NUM_OUT]
//
// Inbound FSM (per channel)
//   state       | meaning
//   IN_IDLE     | waiting for the synchronised req to rise, ack low
//   IN_ACK      | req seen, ack high, waiting for the req to fall
//
// Outbound FSM (per channel)
//   state       | meaning
//   OUT_IDLE    | req low; starts a handshake when events are pending
//   OUT_REQ     | req high, waiting for the synchronised ack to rise
//   OUT_RELEASE | req low, waiting for the synchronised ack to fall
// ---------------------------------------------------------------------------
module ext_trigger_bridge #(
  parameter int NUM_IN      = 4,
  parameter int NUM_OUT     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_IN-1:0]               trig_in_req_i,
  output logic [NUM_IN-1:0]               trig_in_ack_o,
  input  logic [NUM_IN-1:0]               trig_in_mask_i,
  output logic [NUM_IN-1:0]               ext_trigger_o,
  input  logic [NUM_OUT-1:0]              core_ext_trigger_i,
  output logic [NUM_OUT-1:0]              trig_out_req_o,
  input  logic [NUM_OUT-1:0]              trig_out_ack_i,
  input  logic                            trig_out_clear_i,
  output logic [NUM_OUT-1:0][PEND_W-1:0]  trig_out_pending_o,
  output logic [NUM_OUT-1:0]              trig_out_overflow_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_REQ     = 2'd1,
    OUT_RELEASE = 2'd2
  } out_state_e;

  // -------------------------------------------------------------------------
  // Synchronisers for the asynchronous req (inbound) and ack (outbound) lines
  // -------------------------------------------------------------------------
  logic [NUM_IN-1:0]  in_sync_q  [SYNC_STAGES];
  logic [NUM_OUT-1:0] ack_sync_q [SYNC_STAGES];
  logic [NUM_IN-1:0]  in_s;
  logic [NUM_OUT-1:0] out_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        in_sync_q[i]  <= '0;
        ack_sync_q[i] <= '0;
      end
    end else begin
      in_sync_q[0]  <= trig_in_req_i;
      ack_sync_q[0] <= trig_out_ack_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        in_sync_q[i]  <= in_sync_q[i-1];
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign in_s  = in_sync_q[SYNC_STAGES-1];
  assign out_a = ack_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Inbound handshake FSMs
  // -------------------------------------------------------------------------
  in_state_e         in_state_q [NUM_IN];
  in_state_e         in_state_d [NUM_IN];
  logic [NUM_IN-1:0] in_pulse_d;

  always_comb begin
    in_pulse_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_state_d[i] = in_state_q[i];
      case (in_state_q[i])
        IN_IDLE: begin
          if (in_s[i]) begin
            in_state_d[i] = IN_ACK;
            // mask only matters at the start of a handshake
            in_pulse_d[i] = ~trig_in_mask_i[i];
          end
        end
        IN_ACK: begin
          if (!in_s[i]) begin
            in_state_d[i] = IN_IDLE;
          end
        end
        default: in_state_d[i] = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_state_q[i] <= IN_IDLE;
      end
      trig_in_ack_o <= '0;
      ext_trigger_o <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_state_q[i]    <= in_state_d[i];
        trig_in_ack_o[i] <= (in_state_d[i] == IN_ACK);
      end
      ext_trigger_o <= in_pulse_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outbound event capture, pending counters and handshake FSMs
  // -------------------------------------------------------------------------
  out_state_e                      out_state_q [NUM_OUT];
  out_state_e                      out_state_d [NUM_OUT];
  logic [NUM_OUT-1:0]              core_d_q;
  logic [NUM_OUT-1:0]              ev;
  logic [NUM_OUT-1:0]              dep;
  logic [NUM_OUT-1:0][PEND_W-1:0]  pend_d;
  logic [NUM_OUT-1:0]              ovf_d;

  // A held level counts as a single event.
  assign ev = core_ext_trigger_i & ~core_d_q;

  always_comb begin
    dep    = '0;
    pend_d = trig_out_pending_o;
    ovf_d  = trig_out_overflow_o;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_state_d[i] = out_state_q[i];
      case (out_state_q[i])
        OUT_IDLE: begin
          // a stale ack from the far side must be gone before a new req
          if ((trig_out_pending_o[i] != '0) && !out_a[i]) begin
            out_state_d[i] = OUT_REQ;
            dep[i]         = 1'b1;
          end
        end
        OUT_REQ: begin
          if (out_a[i]) begin
            out_state_d[i] = OUT_RELEASE;
          end
        end
        OUT_RELEASE: begin
          if (!out_a[i]) begin
            out_state_d[i] = OUT_IDLE;
          end
        end
        default: out_state_d[i] = OUT_IDLE;
      endcase

      // Clear wins over counting, but an event in the clear cycle survives.
      // A departure in that cycle still goes ahead; its event is dropped
      // along with the rest of the queue.
      if (trig_out_clear_i) begin
        pend_d[i] = ev[i] ? PEND_ONE : '0;
        ovf_d[i]  = 1'b0;
      end else if (ev[i] && !dep[i]) begin
        if (trig_out_pending_o[i] == PEND_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = trig_out_pending_o[i] + PEND_ONE;
        end
      end else if (!ev[i] && dep[i]) begin
        pend_d[i] = trig_out_pending_o[i] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_state_q[i] <= OUT_IDLE;
      end
      core_d_q            <= '0;
      trig_out_req_o      <= '0;
      trig_out_pending_o  <= '0;
      trig_out_overflow_o <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_state_q[i]    <= out_state_d[i];
        trig_out_req_o[i] <= (out_state_d[i] == OUT_REQ);
      end
      core_d_q            <= core_ext_trigger_i;
      trig_out_pending_o  <= pend_d;
      trig_out_overflow_o <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ext_trigger_bridge.sv
module tb_ext_trigger_bridge;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 2;
  localparam int PEND_W  = 4;

  logic                            clk = 1'b0;
  logic                            reset_n = 1'b1;
  logic [NUM_IN-1:0]               trig_in_req_i = '0;
  logic [NUM_IN-1:0]               trig_in_ack_o;
  logic [NUM_IN-1:0]               trig_in_mask_i = '0;
  logic [NUM_IN-1:0]               ext_trigger_o;
  logic [NUM_OUT-1:0]              core_ext_trigger_i = '0;
  logic [NUM_OUT-1:0]              trig_out_req_o;
  logic [NUM_OUT-1:0]              trig_out_ack_i;
  logic                            trig_out_clear_i = 1'b0;
  logic [NUM_OUT-1:0][PEND_W-1:0]  trig_out_pending_o;
  logic [NUM_OUT-1:0]              trig_out_overflow_o;

  ext_trigger_bridge #(
    .NUM_IN      (NUM_IN),
    .NUM_OUT     (NUM_OUT),
    .SYNC_STAGES (2),
    .PEND_W      (PEND_W)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .trig_in_req_i       (trig_in_req_i),
    .trig_in_ack_o       (trig_in_ack_o),
    .trig_in_mask_i      (trig_in_mask_i),
    .ext_trigger_o       (ext_trigger_o),
    .core_ext_trigger_i  (core_ext_trigger_i),
    .trig_out_req_o      (trig_out_req_o),
    .trig_out_ack_i      (trig_out_ack_i),
    .trig_out_clear_i    (trig_out_clear_i),
    .trig_out_pending_o  (trig_out_pending_o),
    .trig_out_overflow_o (trig_out_overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected inbound pulse: value and the cycle it must appear in
  typedef struct {
    logic [NUM_IN-1:0] val;
    int                at;
  } in_exp_t;

  // expected outbound req rise: channel and pending count right after it
  typedef struct {
    int                ch;
    logic [PEND_W-1:0] pend;
  } out_exp_t;

  in_exp_t  in_q[$];
  out_exp_t out_q[$];
  in_exp_t  mon_ie;
  out_exp_t mon_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- far-side ack responder (5-cycle reaction) --------------
  logic [NUM_OUT-1:0] ack_r     = '0;
  logic [NUM_OUT-1:0] resp_en   = '1;
  logic [NUM_OUT-1:0] resp_hold = '0;
  int                 rcnt [NUM_OUT];

  assign trig_out_ack_i = ack_r;

  initial begin
    for (int ch = 0; ch < NUM_OUT; ch++) rcnt[ch] = 0;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_OUT; ch++) begin
        if (resp_hold[ch]) begin
          ack_r[ch] = 1'b1;
          rcnt[ch]  = 0;
        end else if (!resp_en[ch]) begin
          rcnt[ch] = 0;
        end else if (ack_r[ch] != trig_out_req_o[ch]) begin
          rcnt[ch]++;
          if (rcnt[ch] == 5) begin
            ack_r[ch] = trig_out_req_o[ch];
            rcnt[ch]  = 0;
          end
        end else begin
          rcnt[ch] = 0;
        end
      end
    end
  end

  // ---------------- monitor: pops expectations when outputs appear ---------
  logic [NUM_OUT-1:0] req_prev = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (ext_trigger_o !== '0) begin
        if (in_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL in_pulse_unexpected: got %b expected no pulse (cycle %0d)", ext_trigger_o, cyc);
        end else begin
          mon_ie = in_q.pop_front();
          check("in_pulse_value", 32'(ext_trigger_o), 32'(mon_ie.val));
          check("in_pulse_cycle", cyc, mon_ie.at);
        end
      end
      for (int ch = 0; ch < NUM_OUT; ch++) begin
        if (trig_out_req_o[ch] && !req_prev[ch]) begin
          if (out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_req_unexpected: got rise on ch%0d expected none (cycle %0d)", ch, cyc);
          end else begin
            mon_oe = out_q.pop_front();
            check("out_req_channel", ch, mon_oe.ch);
            check("out_req_pending", 32'(trig_out_pending_o[ch]), 32'(mon_oe.pend));
          end
        end
      end
      req_prev = trig_out_req_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of sequence");
    $fatal(1);
  end

  // drive point: 2 time units after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // sample point: falling edge after n more rising edges
  task automatic sample_at(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic in_exp_t mk_in(input logic [NUM_IN-1:0] v, input int at);
    in_exp_t e;
    e.val = v;
    e.at  = at;
    return e;
  endfunction

  function automatic out_exp_t mk_out(input int ch, input logic [PEND_W-1:0] p);
    out_exp_t e;
    e.ch   = ch;
    e.pend = p;
    return e;
  endfunction

  initial begin
    #1 reset_n = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_in_ack",   32'(trig_in_ack_o),       0);
    check("rst_ext_trig", 32'(ext_trigger_o),       0);
    check("rst_out_req",  32'(trig_out_req_o),      0);
    check("rst_pending",  32'(trig_out_pending_o),  0);
    check("rst_overflow", 32'(trig_out_overflow_o), 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // T1: inbound ch2, pulse 3 edges after req, ack follows req by 3 edges
    trig_in_req_i[2] = 1'b1;
    in_q.push_back(mk_in(4'b0100, cyc + 3));
    sample_at(2);
    check("t1_ack_before", 32'(trig_in_ack_o[2]), 0);
    sample_at(1);
    check("t1_ack_rise", 32'(trig_in_ack_o[2]), 1);
    tick(5);
    trig_in_req_i[2] = 1'b0;
    sample_at(2);
    check("t1_ack_hold", 32'(trig_in_ack_o[2]), 1);
    sample_at(1);
    check("t1_ack_fall", 32'(trig_in_ack_o[2]), 0);
    tick(2);

    // T2: inbound ch0 masked; mask dropped mid-handshake must not pulse
    trig_in_mask_i[0] = 1'b1;
    trig_in_req_i[0]  = 1'b1;
    sample_at(3);
    check("t2_ack_rise", 32'(trig_in_ack_o[0]), 1);
    tick(1);
    trig_in_mask_i[0] = 1'b0;
    tick(4);
    trig_in_req_i[0] = 1'b0;
    sample_at(3);
    check("t2_ack_fall", 32'(trig_in_ack_o[0]), 0);
    tick(2);

    // T3: outbound ch1, stale ack holds departures off while 3 events queue
    resp_hold[1] = 1'b1;
    tick(4);
    out_q.push_back(mk_out(1, 4'd2));
    out_q.push_back(mk_out(1, 4'd1));
    out_q.push_back(mk_out(1, 4'd0));
    for (int k = 0; k < 3; k++) begin
      core_ext_trigger_i[1] = 1'b1;
      tick(1);
      core_ext_trigger_i[1] = 1'b0;
      tick(1);
    end
    @(negedge clk);
    check("t3_pending3", 32'(trig_out_pending_o[1]), 3);
    check("t3_no_ovf",   32'(trig_out_overflow_o[1]), 0);
    tick(1);
    resp_hold[1] = 1'b0;
    tick(120);
    check("t3_pending0", 32'(trig_out_pending_o[1]), 0);
    check("t3_all_sent", out_q.size(), 0);

    // T4: outbound ch0, level held 20 cycles -> one handshake
    out_q.push_back(mk_out(0, 4'd0));
    core_ext_trigger_i[0] = 1'b1;
    tick(20);
    core_ext_trigger_i[0] = 1'b0;
    tick(40);
    check("t4_all_sent", out_q.size(), 0);
    check("t4_pending0", 32'(trig_out_pending_o[0]), 0);
    check("t4_req_low",  32'(trig_out_req_o[0]), 0);

    // T5: outbound ch0 stalled, 17 events saturate, clear with coincident event
    resp_en[0] = 1'b0;
    out_q.push_back(mk_out(0, 4'd0));
    for (int k = 0; k < 17; k++) begin
      core_ext_trigger_i[0] = 1'b1;
      tick(1);
      core_ext_trigger_i[0] = 1'b0;
      tick(1);
    end
    @(negedge clk);
    check("t5_pending_sat", 32'(trig_out_pending_o[0]), 15);
    check("t5_overflow",    32'(trig_out_overflow_o[0]), 1);
    check("t5_req_high",    32'(trig_out_req_o[0]), 1);
    tick(1);
    core_ext_trigger_i[0] = 1'b1;
    trig_out_clear_i      = 1'b1;
    tick(1);
    core_ext_trigger_i[0] = 1'b0;
    trig_out_clear_i      = 1'b0;
    @(negedge clk);
    check("t5_clear_pending", 32'(trig_out_pending_o[0]), 1);
    check("t5_clear_ovf",     32'(trig_out_overflow_o[0]), 0);
    sample_at(3);
    check("t5_req_still", 32'(trig_out_req_o[0]), 1);
    check("t5_pend_still", 32'(trig_out_pending_o[0]), 1);

    // T6: reset mid-handshake (outbound ch0 in REQ, inbound ch1 in ACK)
    tick(1);
    trig_in_req_i[1] = 1'b1;
    in_q.push_back(mk_in(4'b0010, cyc + 3));
    sample_at(4);
    check("t6_in_ack_up", 32'(trig_in_ack_o[1]), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_req",     32'(trig_out_req_o),      0);
    check("t6_rst_ack",     32'(trig_in_ack_o),       0);
    check("t6_rst_pending", 32'(trig_out_pending_o),  0);
    check("t6_rst_ovf",     32'(trig_out_overflow_o), 0);
    tick(2);
    reset_n = 1'b1;
    in_q.push_back(mk_in(4'b0010, cyc + 3));
    resp_en[0] = 1'b1;
    sample_at(3);
    check("t6_in_ack_again", 32'(trig_in_ack_o[1]), 1);
    tick(2);
    out_q.push_back(mk_out(0, 4'd0));
    core_ext_trigger_i[0] = 1'b1;
    tick(1);
    core_ext_trigger_i[0] = 1'b0;
    tick(40);
    check("t6_out_done", 32'(trig_out_req_o[0]), 0);
    trig_in_req_i[1] = 1'b0;
    sample_at(3);
    check("t6_in_ack_fall", 32'(trig_in_ack_o[1]), 0);
    tick(5);

    check("end_in_queue",  in_q.size(),  0);
    check("end_out_queue", out_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
